// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: busy bits, issue acceptance and pending-write count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  output logic [NREG-1:0] busy,
  output logic [AW:0]     pend_cnt
);
  logic            set_en;
  logic            clr_en;
  logic [NREG-1:0] busy_nx;
  logic [AW:0]     inc;
  logic [AW:0]     dec;

  assign issue_ready = (issue_rd == '0) || !busy[issue_rd];
  assign set_en      = issue_valid && issue_ready && (issue_rd != '0);
  assign clr_en      = we && (waddr != '0) && busy[waddr];
  assign inc         = {{AW{1'b0}}, set_en};
  assign dec         = {{AW{1'b0}}, clr_en};

  // Clear is applied before set so a same-register reservation wins.
  always_comb begin
    busy_nx = busy;
    if (clr_en) busy_nx[waddr] = 1'b0;
    if (set_en) busy_nx[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nx;
      pend_cnt <= pend_cnt + inc - dec;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised NRD-read/1-write register file with write-pending scoreboard.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  output logic [AW:0]       pend_cnt
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .we          (we),
    .waddr       (waddr),
    .busy        (busy),
    .pend_cnt    (pend_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    rdata = '0;
    rbusy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra = raddr[p*AW +: AW];
      rdata[p*XLEN +: XLEN] = (ra == '0) ? '0 : regs[ra];
      rbusy[p] = busy[ra];
`ifdef REGFILE_BYPASS_EN
      if (we && (waddr != '0) && (waddr == ra)) begin
        rdata[p*XLEN +: XLEN] = wdata;
        rbusy[p] = 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .pend_cnt    (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
    #1;
  endtask

  initial begin
    rst = 1'b1; raddr = '0; issue_valid = 1'b0; issue_rd = '0;
    we = 1'b0; waddr = '0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_pend", 64'(pend_cnt), 64'd0);
    chk("reset_ready", 64'(issue_ready), 64'd1);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("reset_rdata0", 64'(rdata[31:0]), 64'd0);
      chk("reset_rdata1", 64'(rdata[63:32]), 64'd0);
      chk("reset_rbusy", 64'(rbusy), 64'd0);
    end

    // write x5, read next cycle
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    rd(5'd5, 5'd5);
    chk("x5_rdata0", 64'(rdata[31:0]), 64'hDEADBEEF);
    chk("x5_rdata1", 64'(rdata[63:32]), 64'hDEADBEEF);
    chk("x5_nonbusy", 64'(rbusy), 64'd0);

    // write to x0 discarded
    we = 1'b1; waddr = ZERO_REG; wdata = 32'h1234;
    tick();
    we = 1'b0;
    rd(ZERO_REG, 5'd5);
    chk("x0_rdata", 64'(rdata[31:0]), 64'd0);
    chk("x0_pend", 64'(pend_cnt), 64'd0);

    // reserve x7, then WAW stall
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("x7_ready_first", 64'(issue_ready), 64'd1);
    tick();
    rd(5'd7, 5'd0);
    chk("x7_ready_stall", 64'(issue_ready), 64'd0);
    chk("x7_rbusy", 64'(rbusy), 64'b01);
    chk("x7_pend", 64'(pend_cnt), 64'd1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("x7_pend_held", 64'(pend_cnt), 64'd1);
    we = 1'b1; waddr = 5'd7; wdata = 32'h55;
    tick();
    we = 1'b0;
    #1;
    chk("x7_wb_rbusy", 64'(rbusy), 64'd0);
    chk("x7_wb_pend", 64'(pend_cnt), 64'd0);
    chk("x7_wb_ready", 64'(issue_ready), 64'd1);
    chk("x7_wb_rdata", 64'(rdata[31:0]), 64'h55);

    // simultaneous issue and writeback to x9
    issue_valid = 1'b1; issue_rd = 5'd9;
    we = 1'b1; waddr = 5'd9; wdata = 32'hAA;
    #1;
    chk("x9_ready", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0; we = 1'b0;
    rd(5'd9, 5'd0);
    chk("x9_rdata", 64'(rdata[31:0]), 64'hAA);
    chk("x9_rbusy", 64'(rbusy), 64'b01);
    chk("x9_pend", 64'(pend_cnt), 64'd1);

    // x3 busy, writeback while reading
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("x3_pend", 64'(pend_cnt), 64'd2);
    we = 1'b1; waddr = 5'd3; wdata = 32'h77;
    rd(5'd0, 5'd3);
`ifdef REGFILE_BYPASS_EN
    chk("x3_same_rdata", 64'(rdata[63:32]), 64'h77);
    chk("x3_same_rbusy", 64'(rbusy), 64'b00);
`else
    chk("x3_same_rdata", 64'(rdata[63:32]), 64'd0);
    chk("x3_same_rbusy", 64'(rbusy), 64'b10);
`endif
    chk("x3_same_ready", 64'(issue_ready), 64'd0);
    tick();
    we = 1'b0;
    #1;
    chk("x3_after_rdata", 64'(rdata[63:32]), 64'h77);
    chk("x3_after_rbusy", 64'(rbusy), 64'd0);
    chk("x3_after_pend", 64'(pend_cnt), 64'd1);

    // fill scoreboard: x9 already busy, the rest fire
    issue_valid = 1'b1;
    for (int i = 1; i < 32; i++) begin
      issue_rd = 5'(i);
      tick();
    end
    #1;
    chk("full_pend", 64'(pend_cnt), 64'd31);
    chk("full_ready", 64'(issue_ready), 64'd0);
    issue_rd = ZERO_REG;
    rd(5'd31, 5'd1);
    chk("full_ready_x0", 64'(issue_ready), 64'd1);
    chk("full_rbusy", 64'(rbusy), 64'b11);

    // reset with writeback and issue active
    rst = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE;
    issue_rd = 5'd0;
    tick();
    rst = 1'b0; we = 1'b0; issue_valid = 1'b0; issue_rd = 5'd5;
    #1;
    chk("rst2_pend", 64'(pend_cnt), 64'd0);
    chk("rst2_ready", 64'(issue_ready), 64'd1);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("rst2_rdata0", 64'(rdata[31:0]), 64'd0);
      chk("rst2_rdata1", 64'(rdata[63:32]), 64'd0);
      chk("rst2_rbusy", 64'(rbusy), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
